regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised integer register file with two write ports and a pending-write scoreboard for long-latency (load) results; the next generation of the decode-stage register file.
- Sits between decode and execute: decode drives source/destination indices, the ALU writeback and memory writeback each own a write port, and `stall` holds the front end while an operand or destination is still pending.
- Register 0 is hard-wired to zero.

Parameters:
- XLEN, 32, data width of every register and data port.
- NREGS, 32, number of architectural registers; power of two, >= 2.
- AW, $clog2(NREGS), index width; derived, not overridden.
- BYPASS, 1, 1 = a same-cycle write is forwarded to the read ports; 0 = reads return the stored value only.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- nrst  in  1  asynchronous active-low reset.
- rs1  in  AW  read index, port 1.
- rs2  in  AW  read index, port 2.
- rs1_data  out  XLEN  read data, port 1.
- rs2_data  out  XLEN  read data, port 2.
- alu_we  in  1  ALU writeback enable.
- alu_rd  in  AW  ALU writeback index.
- alu_data  in  XLEN  ALU writeback data.
- issue_ld  in  1  a load is issuing this cycle; marks ld_rd pending.
- ld_rd  in  AW  destination of the issuing load.
- mem_we  in  1  memory writeback valid; completes a pending load.
- mem_rd  in  AW  memory writeback index.
- mem_data  in  XLEN  memory writeback data.
- flush  in  1  synchronous clear of all pending bits; register contents kept.
- stall  out  1  operand or WAW hazard on a pending register.
- busy  out  NREGS  scoreboard vector, bit i = register i pending.

Behaviour:
- Reset (nrst low, asynchronous): all registers 0, busy = 0.
  - Outputs while in reset: rs*_data = 0, stall = 0.
  - Reset release mid-load: the pending state is lost and later mem_we is accepted normally.
- Reads are combinational, zero latency: rs*_data = reg[rs*].
  - Index 0 always returns 0.
- BYPASS=1 forwarding: if a write to the read index commits this cycle, the read returns the write data.
  - mem write takes precedence over alu write.
- Write commit at the clock edge, only when the index != 0.
- Both write ports target the same index in the same cycle: mem_data is stored, alu_data is dropped.
- Scoreboard, per register i != 0:
  - busy[i] next = 1 when issue_ld & ld_rd == i & !stall.
  - Otherwise busy[i] next = 0 when mem_we & mem_rd == i.
  - Otherwise busy[i] holds.
- Set and clear of the same index in the same cycle: set wins; the register remains pending for the new load.
- busy[0] is never set; issue_ld with ld_rd = 0 is a no-op for the scoreboard.
- flush: busy next = 0, overriding any set in that cycle; register writes in that cycle still commit.
- mem_we to a non-busy index: data is written; no error is raised.
- alu_we to a busy index: data is written and busy is unchanged (the later load result overwrites it).
- stall is combinational and is 1 when any of the following hold:
  - busy[rs1] & rs1 != 0;
  - busy[rs2] & rs2 != 0;
  - issue_ld & busy[ld_rd] & ld_rd != 0 (WAW).
- stall is not cleared by a same-cycle mem_we: it drops one cycle later.
  - Exception: BYPASS=1 and the operand index matches mem_rd, in which case stall is masked for that operand that cycle.
- While stall = 1, issue_ld is ignored.

Test Plan:
- Reset then read: pulse nrst low, read rs1 = 5, rs2 = 31 -> both data 0, busy = 0, stall = 0.
- x0 protection:
  - alu_we, alu_rd = 0, data 0xDEADBEEF, then read rs1 = 0 -> 0.
  - alu_rd = 7 with the same data -> next cycle rs1 = 7 reads 0xDEADBEEF.
- Bypass:
  - BYPASS=1: alu_we rd = 3, data 0x1234, rs1 = 3 in the same cycle -> rs1_data = 0x1234 that cycle.
  - BYPASS=0: same stimulus -> old value that cycle, 0x1234 next cycle.
- Load hazard:
  - issue_ld ld_rd = 9 -> busy[9] = 1 next cycle.
  - rs2 = 9 -> stall = 1 for 3 cycles.
  - mem_we rd = 9, data 0xA5A5A5A5 -> BYPASS=1: stall = 0 and rs2_data = 0xA5A5A5A5 that cycle; busy[9] = 0 after.
- Port conflict and set/clear race:
  - alu_we and mem_we both to rd = 4, data 0x1 / 0x2 -> reg4 = 0x2.
  - issue_ld rd = 4 and mem_we rd = 4 in the same cycle (4 not busy) -> busy[4] = 1.
- Flush and async reset mid-load:
  - busy[6] and busy[8] set, pulse flush -> busy = 0 next cycle.
  - Set busy[6] again, assert nrst low between edges -> busy = 0 immediately.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with ALU and memory write ports and a
// pending-load scoreboard. Register 0 reads as zero and is never written.
module regfile_sb #(
    parameter int unsigned  XLEN   = 32,
    parameter int unsigned  NREGS  = 32,
    parameter bit           BYPASS = 1'b1,
    localparam int unsigned AW     = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [AW-1:0]    rs1,
    input  logic [AW-1:0]    rs2,
    output logic [XLEN-1:0]  rs1_data,
    output logic [XLEN-1:0]  rs2_data,
    input  logic             alu_we,
    input  logic [AW-1:0]    alu_rd,
    input  logic [XLEN-1:0]  alu_data,
    input  logic             issue_ld,
    input  logic [AW-1:0]    ld_rd,
    input  logic             mem_we,
    input  logic [AW-1:0]    mem_rd,
    input  logic [XLEN-1:0]  mem_data,
    input  logic             flush,
    output logic             stall,
    output logic [NREGS-1:0] busy
);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_busy;

    logic [XLEN-1:0]  w_rs1_val;
    logic [XLEN-1:0]  w_rs2_val;
    logic             w_hz_rs1;
    logic             w_hz_rs2;
    logic             w_hz_waw;
    logic             w_stall;
    logic [NREGS-1:0] w_set;
    logic [NREGS-1:0] w_clr;
    logic [NREGS-1:0] w_busy_d;

    // Read port 1: stored value, optionally overridden by a committing write (mem wins).
    always_comb begin
        w_rs1_val = r_regs[rs1];
        if (BYPASS) begin
            if (alu_we && (alu_rd == rs1)) begin
                w_rs1_val = alu_data;
            end
            if (mem_we && (mem_rd == rs1)) begin
                w_rs1_val = mem_data;
            end
        end
        if (rs1 == '0) begin
            w_rs1_val = '0;
        end
    end

    // Read port 2: same forwarding rules as port 1.
    always_comb begin
        w_rs2_val = r_regs[rs2];
        if (BYPASS) begin
            if (alu_we && (alu_rd == rs2)) begin
                w_rs2_val = alu_data;
            end
            if (mem_we && (mem_rd == rs2)) begin
                w_rs2_val = mem_data;
            end
        end
        if (rs2 == '0) begin
            w_rs2_val = '0;
        end
    end

    // Hazard detection; an operand being completed by mem this cycle is covered by forwarding.
    always_comb begin
        w_hz_rs1 = r_busy[rs1] && (rs1 != '0);
        w_hz_rs2 = r_busy[rs2] && (rs2 != '0);
        if (BYPASS && mem_we && (mem_rd == rs1)) begin
            w_hz_rs1 = 1'b0;
        end
        if (BYPASS && mem_we && (mem_rd == rs2)) begin
            w_hz_rs2 = 1'b0;
        end
        w_hz_waw = issue_ld && r_busy[ld_rd] && (ld_rd != '0);
        w_stall  = w_hz_rs1 || w_hz_rs2 || w_hz_waw;
    end

    // Scoreboard next state from one-hot set/clear masks; set beats clear, flush beats all.
    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (issue_ld && !w_stall) begin
            w_set[ld_rd] = 1'b1;
        end
        if (mem_we) begin
            w_clr[mem_rd] = 1'b1;
        end
        w_busy_d    = (r_busy & ~w_clr) | w_set;
        w_busy_d[0] = 1'b0;
        if (flush) begin
            w_busy_d = '0;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_d;
        end
    end

    // Register array writes; the mem assignment comes last so it wins a same-index conflict.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (alu_we && (alu_rd != '0)) begin
                r_regs[alu_rd] <= alu_data;
            end
            if (mem_we && (mem_rd != '0)) begin
                r_regs[mem_rd] <= mem_data;
            end
        end
    end

    // Outputs held quiet while reset is asserted, even if write ports are active.
    always_comb begin
        rs1_data = nrst ? w_rs1_val : '0;
        rs2_data = nrst ? w_rs2_val : '0;
        stall    = nrst && w_stall;
        busy     = r_busy;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed scenarios plus randomized traffic against a behavioural model.
module tb_regfile_sb;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NREGS  = 32;
    localparam int unsigned AW     = 5;
    localparam bit          BYPASS = 1'b1;

    logic             clk = 1'b0;
    logic             nrst = 1'b0;
    logic [AW-1:0]    rs1, rs2, alu_rd, ld_rd, mem_rd;
    logic [XLEN-1:0]  rs1_data, rs2_data, alu_data, mem_data;
    logic             alu_we, issue_ld, mem_we, flush, stall;
    logic [NREGS-1:0] busy;

    always #5 clk = ~clk;

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(BYPASS)) u_dut (
        .clk      (clk),
        .nrst     (nrst),
        .rs1      (rs1),
        .rs2      (rs2),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .alu_we   (alu_we),
        .alu_rd   (alu_rd),
        .alu_data (alu_data),
        .issue_ld (issue_ld),
        .ld_rd    (ld_rd),
        .mem_we   (mem_we),
        .mem_rd   (mem_rd),
        .mem_data (mem_data),
        .flush    (flush),
        .stall    (stall),
        .busy     (busy)
    );

    // Reference state: architectural values and pending flags.
    logic [XLEN-1:0] m_regs [NREGS];
    bit              m_busy [NREGS];
    int              n_total = 0;
    int              n_bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NREGS; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endfunction

    function automatic logic [XLEN-1:0] exp_read(input logic [AW-1:0] idx);
        if (idx == 0) return '0;
        if (BYPASS && mem_we && mem_rd == idx) return mem_data;
        if (BYPASS && alu_we && alu_rd == idx) return alu_data;
        return m_regs[idx];
    endfunction

    function automatic bit exp_stall();
        bit s = 1'b0;
        if (rs1 != 0 && m_busy[rs1] && !(BYPASS && mem_we && mem_rd == rs1)) s = 1'b1;
        if (rs2 != 0 && m_busy[rs2] && !(BYPASS && mem_we && mem_rd == rs2)) s = 1'b1;
        if (issue_ld && ld_rd != 0 && m_busy[ld_rd]) s = 1'b1;
        return s;
    endfunction

    function automatic logic [NREGS-1:0] exp_busy();
        logic [NREGS-1:0] v;
        for (int i = 0; i < NREGS; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic idle();
        alu_we   = 1'b0;
        issue_ld = 1'b0;
        mem_we   = 1'b0;
        flush    = 1'b0;
    endtask

    // Let combinational outputs settle after inputs change, then compare everything.
    task automatic settle();
        #1;
        check_val("rs1_data", rs1_data, exp_read(rs1));
        check_val("rs2_data", rs2_data, exp_read(rs2));
        check_val("stall", 32'(stall), 32'(exp_stall()));
        check_val("busy", busy, exp_busy());
    endtask

    // Cross the rising edge, apply the cycle's effects to the model, return at negedge.
    task automatic advance();
        bit st;
        st = exp_stall();
        @(posedge clk);
        if (alu_we && alu_rd != 0 && !(mem_we && mem_rd == alu_rd)) m_regs[alu_rd] = alu_data;
        if (mem_we && mem_rd != 0) m_regs[mem_rd] = mem_data;
        if (flush) begin
            for (int i = 0; i < NREGS; i++) m_busy[i] = 1'b0;
        end else begin
            if (mem_we) m_busy[mem_rd] = 1'b0;
            if (issue_ld && !st && ld_rd != 0) m_busy[ld_rd] = 1'b1;
        end
        @(negedge clk);
    endtask

    initial begin
        idle();
        rs1 = 5; rs2 = 31; alu_rd = 0; ld_rd = 0; mem_rd = 0;
        alu_data = '0; mem_data = '0;
        model_reset();

        // Reset then read.
        repeat (2) @(negedge clk);
        #1;
        check_val("rst_rs1", rs1_data, 32'h0);
        check_val("rst_rs2", rs2_data, 32'h0);
        check_val("rst_busy", busy, 32'h0);
        check_val("rst_stall", 32'(stall), 32'h0);
        nrst = 1'b1;
        @(negedge clk);
        settle(); advance();

        // x0 protection.
        alu_we = 1'b1; alu_rd = 0; alu_data = 32'hDEADBEEF; rs1 = 0;
        settle(); check_val("x0_bypass", rs1_data, 32'h0); advance();
        idle();
        settle(); check_val("x0_read", rs1_data, 32'h0); advance();
        alu_we = 1'b1; alu_rd = 7;
        settle(); advance();
        idle(); rs1 = 7;
        settle(); check_val("x7_read", rs1_data, 32'hDEADBEEF); advance();

        // Same-cycle forwarding.
        alu_we = 1'b1; alu_rd = 3; alu_data = 32'h1234; rs1 = 3;
        settle(); check_val("alu_fwd", rs1_data, 32'h1234); advance();
        idle();

        // Load hazard.
        rs1 = 0; rs2 = 0; issue_ld = 1'b1; ld_rd = 9;
        settle(); advance();
        idle();
        settle(); check_val("busy9_set", 32'(busy[9]), 32'h1); advance();
        rs2 = 9;
        for (int k = 0; k < 3; k++) begin
            settle(); check_val("ld_stall", 32'(stall), 32'h1); advance();
        end
        mem_we = 1'b1; mem_rd = 9; mem_data = 32'hA5A5A5A5;
        settle();
        check_val("ld_fwd_stall", 32'(stall), 32'h0);
        check_val("ld_fwd_data", rs2_data, 32'hA5A5A5A5);
        advance();
        idle();
        settle(); check_val("busy9_clr", 32'(busy[9]), 32'h0); advance();

        // Write-port conflict: mem wins.
        rs2 = 0;
        alu_we = 1'b1; mem_we = 1'b1; alu_rd = 4; mem_rd = 4; alu_data = 32'h1; mem_data = 32'h2;
        settle(); advance();
        idle(); rs1 = 4;
        settle(); check_val("conflict", rs1_data, 32'h2); advance();

        // Set and clear of the same index: set wins.
        rs1 = 0;
        issue_ld = 1'b1; ld_rd = 4; mem_we = 1'b1; mem_rd = 4; mem_data = 32'h3;
        settle(); advance();
        idle();
        settle(); check_val("set_wins", 32'(busy[4]), 32'h1); advance();
        mem_we = 1'b1; mem_rd = 4; mem_data = 32'h44;
        settle(); advance();
        idle();

        // WAW: second load to a pending register stalls and is ignored.
        issue_ld = 1'b1; ld_rd = 11;
        settle(); advance();
        settle(); check_val("waw_stall", 32'(stall), 32'h1); advance();
        idle();
        mem_we = 1'b1; mem_rd = 11; mem_data = 32'hB;
        settle(); advance();
        idle();
        settle(); check_val("waw_clr", 32'(busy[11]), 32'h0); advance();

        // Flush overrides a same-cycle set.
        issue_ld = 1'b1; ld_rd = 6; settle(); advance();
        ld_rd = 8; settle(); advance();
        idle();
        settle(); check_val("pre_flush", busy, 32'h0000_0140); advance();
        flush = 1'b1; issue_ld = 1'b1; ld_rd = 10;
        settle(); advance();
        idle();
        settle(); check_val("flushed", busy, 32'h0); advance();

        // Asynchronous reset between edges while a load is pending.
        issue_ld = 1'b1; ld_rd = 6; settle(); advance();
        idle(); rs1 = 6;
        settle(); check_val("busy6", 32'(busy[6]), 32'h1);
        #2 nrst = 1'b0;
        #1;
        check_val("async_busy", busy, 32'h0);
        check_val("async_stall", 32'(stall), 32'h0);
        check_val("async_rs1", rs1_data, 32'h0);
        model_reset();
        @(negedge clk);
        nrst = 1'b1;
        mem_we = 1'b1; mem_rd = 6; mem_data = 32'h77; rs1 = 0;
        settle(); advance();
        idle(); rs1 = 6;
        settle(); check_val("post_rst_mem", rs1_data, 32'h77); advance();

        // Randomized traffic concentrated on a few registers to provoke hazards.
        for (int c = 0; c < 3000; c++) begin
            rs1      = AW'($urandom_range(0, 15));
            rs2      = AW'($urandom_range(0, 15));
            alu_we   = ($urandom_range(0, 99) < 50);
            alu_rd   = AW'($urandom_range(0, 15));
            alu_data = $urandom;
            issue_ld = ($urandom_range(0, 99) < 30);
            ld_rd    = AW'($urandom_range(0, 15));
            mem_we   = ($urandom_range(0, 99) < 35);
            mem_rd   = AW'($urandom_range(0, 15));
            mem_data = $urandom;
            flush    = ($urandom_range(0, 99) < 2);
            settle();
            advance();
        end

        idle();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
